pipe_stage_skid: RTL

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries separate control and data payloads.
//  - Valid/ready handshake with a 2-entry skid buffer, so backpressure never

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register: main + skid entry, valid/ready handshake, flush to bubble.
// Statistics counters (stall_cnt, bubble_cnt) exist only when PIPE_STATS_EN is defined.
module pipe_stage_skid #(
  parameter int CTRL_W      = 16,
  parameter int DATA_W      = 96,
  parameter int ZERO_BUBBLE = 1,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, out_valid_q;
  logic [1:0]          occ_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;

  logic accept, deliver;
  logic load_main_in, load_main_skid, load_skid, clear_ctrl;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  // NOTE: every variable gets a default first so the combinational block never infers a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = BUSY;
        BUSY: begin
          if (accept && !deliver)      state_d = FULL;
          else if (!accept && deliver) state_d = EMPTY;
        end
        FULL:    if (deliver) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  assign load_main_in   = !flush && accept &&
                          ((state_q == EMPTY) || ((state_q == BUSY) && deliver));
  assign load_main_skid = !flush && (state_q == FULL) && deliver;
  assign load_skid      = !flush && (state_q == BUSY) && accept && !deliver;
  // Any move into EMPTY zeroes the control word so a bubble reads as a nop.
  assign clear_ctrl     = (ZERO_BUBBLE != 0) && (state_d == EMPTY);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= (state_d == FULL) ? 2'd2 : ((state_d == BUSY) ? 2'd1 : 2'd0);
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end else if (clear_ctrl) begin
        main_ctrl_q <= '0;
      end
    end
  end

  // NOTE: the skid entry is storage only; its contents are never observed unless FULL, so it has no reset.
  always_ff @(posedge CLK) begin
    if (load_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_data_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  // Saturating event counters; flush does not touch them, only RST clears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}}))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
